// File: rtl/mux_pkg.sv
// Shared state encoding and the 2:1 select function used by the deserializer and its bench.
package mux_pkg;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_e;

    function automatic logic mux2(input logic a, input logic b, input logic c);
        return (a & ~c) | (b & c);
    endfunction

endpackage

// File: rtl/mux_deser_shift.sv
// Bit accumulator: shifts accepted bits in MSB-first and strobes when a word completes.
module mux_deser_shift #(
    parameter int unsigned WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    input  logic                     z,
    output logic [$clog2(WIDTH)-1:0] bit_count,
    output logic [WIDTH-1:0]         done_word,
    output logic                     complete
);

    localparam int unsigned CW = $clog2(WIDTH);

    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [CW-1:0]    bit_count_q, bit_count_d;

    // The strobe coincides with the accepting edge; the top registers the word on that edge.
    always_comb begin
        shreg_d     = shreg_q;
        bit_count_d = bit_count_q;
        complete    = in_valid && (bit_count_q == CW'(WIDTH - 1));
        done_word   = {shreg_q[WIDTH-2:0], z};
        if (in_valid) begin
            shreg_d     = {shreg_q[WIDTH-2:0], z};
            bit_count_d = complete ? '0 : bit_count_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg_q     <= '0;
            bit_count_q <= '0;
        end else begin
            shreg_q     <= shreg_d;
            bit_count_q <= bit_count_d;
        end
    end

    assign bit_count = bit_count_q;

endmodule

// File: rtl/mux_deser.sv
// Capture stage for z = mux2(a, b, c): assembles WIDTH-bit words and offers them on valid/ready.
module mux_deser
    import mux_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     a,
    input  logic                     b,
    input  logic                     c,
    input  logic                     in_valid,
    output logic [WIDTH-1:0]         word,
    output logic                     word_valid,
    input  logic                     word_ready,
    output logic [$clog2(WIDTH)-1:0] bit_count,
    output logic                     overflow
);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] word_q, word_d;
    logic             overflow_q, overflow_d;
    logic [WIDTH-1:0] done_word;
    logic             complete;
    logic             z;

    assign z = mux2(a, b, c);

    mux_deser_shift #(
        .WIDTH(WIDTH)
    ) u_shift (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .z        (z),
        .bit_count(bit_count),
        .done_word(done_word),
        .complete (complete)
    );

    always_comb begin
        state_d    = state_q;
        word_d     = word_q;
        overflow_d = overflow_q;
        case (state_q)
            EMPTY: begin
                if (complete) begin
                    state_d = FULL;
                    word_d  = done_word;
                end
            end
            FULL: begin
                // A completion during a transfer replaces the word; without one the new word is lost.
                if (complete) begin
                    if (word_ready) word_d = done_word;
                    else            overflow_d = 1'b1;
                end else if (word_ready) begin
                    state_d = EMPTY;
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= EMPTY;
            word_q     <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            word_q     <= word_d;
            overflow_q <= overflow_d;
        end
    end

    assign word       = word_q;
    assign word_valid = (state_q == FULL);
    assign overflow   = overflow_q;

endmodule

// File: tb/tb_mux_deser.sv
// Directed bench for mux_deser with WIDTH=8: sweep table plus hand-written handshake sequences.
module tb_mux_deser;
    import mux_pkg::*;

    localparam int unsigned WIDTH = 8;

    logic             clk;
    logic             rst_n;
    logic             a, b, c;
    logic             in_valid;
    logic [WIDTH-1:0] word;
    logic             word_valid;
    logic             word_ready;
    logic [2:0]       bit_count;
    logic             overflow;

    int errors = 0;
    int checks = 0;
    int alt    = 0;

    typedef struct {
        logic       a;
        logic       b;
        logic       c;
        logic       exp_z;
        logic [2:0] exp_cnt;
    } vec_t;

    vec_t sweep [8];

    mux_deser #(
        .WIDTH(WIDTH)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .a         (a),
        .b         (b),
        .c         (c),
        .in_valid  (in_valid),
        .word      (word),
        .word_valid(word_valid),
        .word_ready(word_ready),
        .bit_count (bit_count),
        .overflow  (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drive one accepted bit, alternating which select input carries it.
    task automatic send(input logic v, input logic rdy);
        if (alt[0]) begin c = 1'b1; b = v; a = ~v; end
        else        begin c = 1'b0; a = v; b = ~v; end
        alt++;
        in_valid   = 1'b1;
        word_ready = rdy;
        step();
        in_valid = 1'b0;
    endtask

    task automatic send_word(input logic [7:0] w, input int n, input logic rdy);
        for (int i = 0; i < n; i++) send(w[7-i], rdy);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_word"}, 32'(word), 32'h0);
        chk({tag, "_valid"}, 32'(word_valid), 32'h0);
        chk({tag, "_cnt"}, 32'(bit_count), 32'h0);
        chk({tag, "_ovf"}, 32'(overflow), 32'h0);
    endtask

    initial begin
        // Sweep order {c,a,b} counting 000..111 gives z = 0,0,1,1,0,1,0,1.
        sweep[0] = '{a:0, b:0, c:0, exp_z:0, exp_cnt:3'd1};
        sweep[1] = '{a:0, b:1, c:0, exp_z:0, exp_cnt:3'd2};
        sweep[2] = '{a:1, b:0, c:0, exp_z:1, exp_cnt:3'd3};
        sweep[3] = '{a:1, b:1, c:0, exp_z:1, exp_cnt:3'd4};
        sweep[4] = '{a:0, b:0, c:1, exp_z:0, exp_cnt:3'd5};
        sweep[5] = '{a:0, b:1, c:1, exp_z:1, exp_cnt:3'd6};
        sweep[6] = '{a:1, b:0, c:1, exp_z:0, exp_cnt:3'd7};
        sweep[7] = '{a:1, b:1, c:1, exp_z:1, exp_cnt:3'd0};

        rst_n = 1'b0; a = 1'b1; b = 1'b0; c = 1'b1; in_valid = 1'b1; word_ready = 1'b1;
        #12;
        chk_all_zero("reset");
        in_valid = 1'b0;
        @(negedge clk); rst_n = 1'b1;

        // Sweep
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("model_z%0d", i), 32'(mux2(sweep[i].a, sweep[i].b, sweep[i].c)), 32'(sweep[i].exp_z));
            a = sweep[i].a; b = sweep[i].b; c = sweep[i].c;
            in_valid = 1'b1; word_ready = 1'b1;
            step();
            chk($sformatf("sweep_cnt%0d", i), 32'(bit_count), 32'(sweep[i].exp_cnt));
            chk($sformatf("sweep_valid%0d", i), 32'(word_valid), (i == 7) ? 32'h1 : 32'h0);
        end
        in_valid = 1'b0;
        chk("sweep_word", 32'(word), 32'h35);
        step();
        chk("sweep_drain", 32'(word_valid), 32'h0);

        // Gaps of 3 idle cycles between bits
        for (int i = 0; i < 8; i++) begin
            a = sweep[i].a; b = sweep[i].b; c = sweep[i].c;
            in_valid = 1'b1; word_ready = 1'b0;
            step();
            in_valid = 1'b0;
            for (int g = 0; g < 3; g++) begin
                step();
                if (i == 2) chk($sformatf("gap_hold%0d", g), 32'(bit_count), 32'h3);
            end
        end
        chk("gap_word", 32'(word), 32'h35);
        chk("gap_valid", 32'(word_valid), 32'h1);
        word_ready = 1'b1;
        step();
        chk("gap_drain", 32'(word_valid), 32'h0);

        // Back-pressure with overflow
        send_word(8'hA5, 8, 1'b0);
        chk("bp_w1_valid", 32'(word_valid), 32'h1);
        chk("bp_w1_word", 32'(word), 32'hA5);
        send_word(8'h3C, 7, 1'b0);
        chk("bp_hold_word", 32'(word), 32'hA5);
        chk("bp_pre_ovf", 32'(overflow), 32'h0);
        send(1'b0, 1'b0);
        chk("bp_w2_word", 32'(word), 32'hA5);
        chk("bp_w2_valid", 32'(word_valid), 32'h1);
        chk("bp_ovf", 32'(overflow), 32'h1);
        word_ready = 1'b1;
        step();
        chk("bp_drain", 32'(word_valid), 32'h0);
        chk("bp_ovf_sticky", 32'(overflow), 32'h1);

        // Asynchronous reset while FULL
        send_word(8'hA5, 8, 1'b0);
        chk("rf_valid", 32'(word_valid), 32'h1);
        #3 rst_n = 1'b0;
        #1;
        chk_all_zero("rst_full");
        @(negedge clk); rst_n = 1'b1;

        // Completion coincides with a transfer
        send_word(8'hA5, 8, 1'b0);
        send_word(8'h3C, 7, 1'b0);
        chk("sim_hold", 32'(word), 32'hA5);
        send(1'b0, 1'b1);
        chk("sim_word", 32'(word), 32'h3C);
        chk("sim_valid", 32'(word_valid), 32'h1);
        chk("sim_ovf", 32'(overflow), 32'h0);
        word_ready = 1'b1;
        step();
        chk("sim_drain", 32'(word_valid), 32'h0);

        // Reset mid-word discards the partial bits
        send_word(8'h00, 5, 1'b1);
        chk("mw_cnt", 32'(bit_count), 32'h5);
        #3 rst_n = 1'b0;
        #1;
        chk("mw_rst_cnt", 32'(bit_count), 32'h0);
        @(negedge clk); rst_n = 1'b1;
        for (int i = 0; i < 7; i++) begin
            send(1'b1, 1'b1);
            chk($sformatf("mw_novalid%0d", i), 32'(word_valid), 32'h0);
        end
        send(1'b1, 1'b1);
        chk("mw_word", 32'(word), 32'hFF);
        chk("mw_valid", 32'(word_valid), 32'h1);
        chk("mw_cnt_wrap", 32'(bit_count), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
